// File: rtl/reg_dump_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_unit_pkg
// Brief    : Shared types and constants for the register dump unit.
//            Holds the FSM state encoding and the beat index constants.
// Revision : 1.0 - initial release
// ============================================================================
package reg_dump_unit_pkg;

  // Number of architectural registers streamed before the optional PC beat
  localparam int NUM_REGS   = 32;

  // Width of the beat index: 0..31 registers, 32 = PC
  localparam int DUMP_IDX_W = 6;

  // Beat index carrying the captured PC
  localparam logic [DUMP_IDX_W-1:0] PC_INDEX       = 6'd32;

  // Beat index of the final register-file entry
  localparam logic [DUMP_IDX_W-1:0] LAST_REG_INDEX = 6'(NUM_REGS - 1);

  // Dump sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FREEZE = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } dump_state_e;

endpackage : reg_dump_unit_pkg
`default_nettype wire

// File: rtl/reg_dump_unit.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_unit
// Brief    : On request, stalls the core, waits for in-flight writebacks to
//            retire, then streams all 32 register-file entries and optionally
//            the PC over a valid/ready port. One FSM carries both the settle
//            counter and the beat sequencer; the output beat is held in its
//            registers while the sink stalls, so no skid buffer is needed.
// Revision : 1.0 - initial release
// ============================================================================
module reg_dump_unit
  import reg_dump_unit_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,     // cycles spent in FREEZE, 1..15
  parameter bit INCLUDE_PC    = 1'b1   // 1 = append PC beat after registers
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] pc_in,
  output logic        cpu_stall,
  output logic [4:0]  rf_rd_addr,
  input  logic [31:0] rf_rd_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [5:0]  dump_index,
  output logic [31:0] dump_data,
  output logic        busy,
  output logic        done
);

  // Value loaded into the settle counter on entry to FREEZE; FREEZE lasts
  // until the counter has been observed at zero, i.e. SETTLE_CYCLES cycles.
  localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);

  dump_state_e r_state;
  logic [3:0]  r_settle_cnt;
  logic [31:0] r_pc;

  logic        w_fire;
  logic        w_last_reg;
  logic        w_last_beat;
  logic [4:0]  w_rd_addr;

  // A beat is accepted on the edge where the sink takes the presented beat
  assign w_fire      = (r_state == SEND) && dump_valid && dump_ready;
  assign w_last_reg  = (dump_index == LAST_REG_INDEX);
  assign w_last_beat = INCLUDE_PC ? (dump_index == PC_INDEX) : w_last_reg;

  // RF read address: the next register is looked up in the cycle the current
  // beat is accepted, so back-to-back beats need no extra read cycle. When
  // leaving FREEZE the default of zero fetches register 0 for the first beat.
  always_comb begin
    w_rd_addr = 5'd0;
    if (w_fire && (dump_index < LAST_REG_INDEX)) begin
      w_rd_addr = dump_index[4:0] + 5'd1;
    end
  end

  assign rf_rd_addr = w_rd_addr;

  // Dump sequencer: settle wait, beat streaming and completion handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_settle_cnt <= 4'd0;
      r_pc         <= 32'd0;
      cpu_stall    <= 1'b0;
      dump_valid   <= 1'b0;
      dump_index   <= 6'd0;
      dump_data    <= 32'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state      <= FREEZE;
            r_settle_cnt <= c_settle_load;
            cpu_stall    <= 1'b1;
            busy         <= 1'b1;
          end
        end

        FREEZE: begin
          if (r_settle_cnt == 4'd0) begin
            // Pipeline has drained: snapshot the PC and present register 0
            r_pc       <= pc_in;
            dump_data  <= rf_rd_data;
            dump_index <= 6'd0;
            dump_valid <= 1'b1;
            r_state    <= SEND;
          end else begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end
        end

        SEND: begin
          if (w_fire) begin
            if (w_last_beat) begin
              dump_valid <= 1'b0;
              done       <= 1'b1;
              r_state    <= FINISH;
            end else if (w_last_reg) begin
              // Only reachable with the PC beat enabled
              dump_data  <= r_pc;
              dump_index <= PC_INDEX;
            end else begin
              dump_data  <= rf_rd_data;
              dump_index <= dump_index + 6'd1;
            end
          end
        end

        FINISH: begin
          // done has been high for this one cycle; release the core
          done      <= 1'b0;
          cpu_stall <= 1'b0;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : reg_dump_unit
`default_nettype wire

// File: tb/tb_reg_dump_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_dump_unit
// Brief    : Self-checking bench for reg_dump_unit. One instance with the PC
//            beat, one without; a behavioural RF returns 0x1000_0000 + addr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_unit;

  localparam int SETTLE = 4;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t exp_tbl [33];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        dump_ready = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] pc_in = 32'h0000_0040;

  logic        start_a, start_b;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] rd_a, rd_b, data_a, data_b;
  logic        stall_a, stall_b, valid_a, valid_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [5:0]  idx_a, idx_b;

  logic        m_stall, m_valid, m_busy, m_done;
  logic [5:0]  m_idx;
  logic [31:0] m_data;

  int checks = 0;
  int failures = 0;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign rd_a    = 32'h1000_0000 + {27'd0, addr_a};
  assign rd_b    = 32'h1000_0000 + {27'd0, addr_b};

  assign m_stall = sel ? stall_b : stall_a;
  assign m_valid = sel ? valid_b : valid_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_done  = sel ? done_b  : done_a;
  assign m_idx   = sel ? idx_b   : idx_a;
  assign m_data  = sel ? data_b  : data_a;

  reg_dump_unit #(.SETTLE_CYCLES(SETTLE), .INCLUDE_PC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .pc_in(pc_in),
    .cpu_stall(stall_a), .rf_rd_addr(addr_a), .rf_rd_data(rd_a),
    .dump_valid(valid_a), .dump_ready(dump_ready), .dump_index(idx_a),
    .dump_data(data_a), .busy(busy_a), .done(done_a)
  );

  reg_dump_unit #(.SETTLE_CYCLES(SETTLE), .INCLUDE_PC(1'b0)) dut_nopc (
    .clk(clk), .rst_n(rst_n), .start(start_b), .pc_in(pc_in),
    .cpu_stall(stall_b), .rf_rd_addr(addr_b), .rf_rd_data(rd_b),
    .dump_valid(valid_b), .dump_ready(dump_ready), .dump_index(idx_b),
    .dump_data(data_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one dump on the selected instance. ready_rand: random backpressure.
  // restart_at: beat at which start is pulsed again (-1 none).
  // reset_at: beat at which rst_n is pulled low and the dump abandoned (-1 none).
  // pc_glitch: change pc_in to DEAD_BEEF partway through SEND.
  task automatic run_dump(input bit use_nopc, input bit ready_rand,
                          input int restart_at, input int reset_at,
                          input bit pc_glitch);
    int beat = 0;
    int lat;
    int cyc = 0;
    int n_exp;
    bit holding = 1'b0;
    logic [5:0]  h_idx;
    logic [31:0] h_data;
    n_exp = use_nopc ? 32 : 33;
    sel = use_nopc;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!m_valid && lat < 20) begin
      check("stall_in_freeze", {31'd0, m_stall}, 32'd1);
      check("busy_in_freeze", {31'd0, m_busy}, 32'd1);
      @(negedge clk);
      lat++;
    end
    check("first_valid_latency", lat, SETTLE + 1);
    if (!m_valid) return;

    while (beat < n_exp && cyc < 500) begin
      if (holding) begin
        check("hold_index", {26'd0, m_idx}, {26'd0, h_idx});
        check("hold_data", m_data, h_data);
        holding = 1'b0;
      end
      if (beat == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_stall", {31'd0, m_stall}, 32'd0);
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_busy", {31'd0, m_busy}, 32'd0);
        check("rst_index", {26'd0, m_idx}, 32'd0);
        dump_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {31'd0, m_busy}, 32'd0);
        return;
      end
      check("send_stall", {31'd0, m_stall}, 32'd1);
      check("send_valid", {31'd0, m_valid}, 32'd1);
      check("beat_index", {26'd0, m_idx}, {26'd0, exp_tbl[beat].idx});
      check("beat_data", m_data, exp_tbl[beat].data);
      dump_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (beat == restart_at) ? 1'b1 : 1'b0;
      if (pc_glitch && beat == 5) pc_in = 32'hDEAD_BEEF;
      if (dump_ready) begin
        beat++;
      end else begin
        holding = 1'b1;
        h_idx   = m_idx;
        h_data  = m_data;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    dump_ready = 1'b0;
    check("beat_count", beat, n_exp);
    check("done_pulse", {31'd0, m_done}, 32'd1);
    check("valid_after_last", {31'd0, m_valid}, 32'd0);
    check("stall_during_done", {31'd0, m_stall}, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, m_done}, 32'd0);
    check("stall_released", {31'd0, m_stall}, 32'd0);
    check("busy_released", {31'd0, m_busy}, 32'd0);
    @(negedge clk);
    check("no_queued_dump", {31'd0, m_busy}, 32'd0);
    pc_in = 32'h0000_0040;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      exp_tbl[i].idx  = 6'(i);
      exp_tbl[i].data = 32'h1000_0000 + 32'(i);
    end
    exp_tbl[32].idx  = 6'd32;
    exp_tbl[32].data = 32'h0000_0040;

    repeat (3) @(negedge clk);
    check("reset_stall", {31'd0, stall_a}, 32'd0);
    check("reset_valid", {31'd0, valid_a}, 32'd0);
    check("reset_busy", {31'd0, busy_a}, 32'd0);
    check("reset_done", {31'd0, done_a}, 32'd0);
    check("reset_index", {26'd0, idx_a}, 32'd0);
    check("reset_data", data_a, 32'd0);
    check("reset_addr", {27'd0, addr_a}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_dump(1'b0, 1'b0, -1, -1, 1'b0);  // basic full dump
    run_dump(1'b0, 1'b1, -1, -1, 1'b0);  // random backpressure
    run_dump(1'b1, 1'b0, -1, -1, 1'b0);  // registers only
    run_dump(1'b0, 1'b0, -1, -1, 1'b1);  // PC changes during SEND
    run_dump(1'b0, 1'b0, 10, -1, 1'b0);  // start ignored mid-dump
    run_dump(1'b0, 1'b0, -1, 17, 1'b0);  // reset mid-dump
    run_dump(1'b0, 1'b0, -1, -1, 1'b0);  // fresh dump after reset

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_reg_dump_unit
`default_nettype wire

// File: doc/reg_dump_unit.md
Name: reg_dump_unit

Overview:
- Hardware reader for architectural state: on request, freezes the MIPS core and streams all 32 register-file entries, then the PC, out over a valid/ready port.
- Sits beside the MIPS top level on a dedicated RF read port; intended for on-chip self-check and FPGA debug, replacing hierarchical peeks.
- Counterpart to the core's writeback path: the core writes state, this block reads it out.

Parameters:
- SETTLE_CYCLES, 4, cycles held in FREEZE after stall assertion so in-flight writebacks retire; legal 1..15.
- INCLUDE_PC, 1, 1 = emit PC as beat index 32 after the registers; 0 = registers only.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a dump.
- pc_in  input  32  current core PC.
- cpu_stall  output  1  freezes core fetch/writeback while high.
- rf_rd_addr  output  5  RF debug read address.
- rf_rd_data  input  32  RF debug read data, combinational from rf_rd_addr.
- dump_valid  output  1  dump_data/dump_index valid.
- dump_ready  input  1  sink accepts beat.
- dump_index  output  6  0..31 = register number, 32 = PC.
- dump_data  output  32  beat payload.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after last beat accepted.

Behaviour:
- Reset (async, rst_n low): state IDLE; cpu_stall, dump_valid, busy, done = 0; dump_index, dump_data, rf_rd_addr, pc capture, settle counter = 0. Takes effect immediately, including mid-dump; core is released at once and a partial dump is abandoned.
- States: IDLE, FREEZE, SEND, FINISH.
- IDLE: start=1 -> FREEZE next edge; cpu_stall=1 from that edge; settle counter loaded with SETTLE_CYCLES-1.
- FREEZE: counter decrements each cycle; at 0, capture pc_in into pc register, load beat 0 (dump_data=rf_rd_data with rf_rd_addr=0, dump_index=0), set dump_valid=1, go SEND. Start-to-first-valid latency = SETTLE_CYCLES+1 cycles.
- SEND: beat transfers on the edge where dump_valid && dump_ready. dump_data/dump_index held stable while dump_ready=0, indefinitely.
  - Transfer of index k<31: load index k+1 from RF (rf_rd_addr driven to k+1 combinationally in the cycle the transfer fires); back-to-back beats at one per cycle with ready held high.
  - Transfer of index 31: INCLUDE_PC=1 -> load index 32 with captured PC; INCLUDE_PC=0 -> dump_valid=0, go FINISH.
  - Transfer of index 32: dump_valid=0, go FINISH.
- FINISH: done=1 for exactly one cycle, cpu_stall=0 and busy=0 next edge, return IDLE.
- start is ignored outside IDLE. start asserted in the same cycle FINISH exits is ignored, with no queued request.
- PC value is the one sampled at the end of FREEZE, not a later pc_in.
- Register 0 is read from the RF like any other entry, with no forced zero. A nonzero value indicates an RF bug.
- dump_index is 6 bits with no wrap; values above 32 are never produced.
- cpu_stall is continuous from the edge after start until the edge after the done pulse.

Decomposition:
- Shared package: state encoding enum (IDLE, FREEZE, SEND, FINISH), constants NUM_REGS=32, PC_INDEX=6'd32, DUMP_IDX_W=6.
- No sub-module. The settle counter and beat sequencer are a single FSM in one file. An optional reusable skid buffer is unnecessary because the output is held in place.

Test Plan:
- Preload RF[i]=32'h1000_0000+i, pc_in=32'h0000_0040, SETTLE_CYCLES=4, dump_ready=1, pulse start -> first dump_valid 5 cycles after start, 33 consecutive beats with index 0..32, data 32'h1000_0000..32'h1000_001F then 32'h0000_0040, done pulses the cycle after the last beat, cpu_stall high throughout and low the cycle after done.
- Same preload, dump_ready toggled randomly with 50% low -> identical 33-beat sequence; data and index unchanged across every ready-low cycle.
- INCLUDE_PC=0 -> exactly 32 beats, last index 31 data 32'h1000_001F, no index 32.
- Change pc_in to 32'hDEAD_BEEF during SEND -> beat 32 still carries the value captured at the end of FREEZE (32'h0000_0040).
- Pulse start again at beat 10 -> ignored, single dump of 33 beats, one done pulse.
- Assert rst_n=0 at beat 17 -> same-cycle cpu_stall=0, dump_valid=0, busy=0. After release, start yields a full fresh dump beginning at index 0.
